seq_alu: RTL and testbench

- Parametrised, multi-cycle signed ALU; next generation of the datapath's single-op add/sub ALU.
- Adds logic ops, sequential shift-add multiply and restoring divide/modulo, a busy/done handshake and status flags.
- Sits between the register file/operand latch and the controller, which issues start and waits for done.

---
 rtl/seq_alu.sv | 221 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Parametrised multi-cycle signed ALU. add/sub/and/or/xor finish
//            in one cycle; mul (shift-add) and div/mod (restoring) iterate
//            one bit per cycle on operand magnitudes, with the sign fixed up
//            in a final cycle.
// Ports    : clk, rst (async, active-high)
//            start, alu_op[2:0], a[WIDTH-1:0], b[WIDTH-1:0]  - request
//            alu_out[WIDTH-1:0], done, busy                  - result/handshake
//            zero, neg, ovf, dbz                             - status flags
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_out,
    output logic             done,
    output logic             busy,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             dbz
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_MUL = 3'b101;
    localparam logic [2:0] c_OP_DIV = 3'b110;
    localparam logic [2:0] c_OP_MOD = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    localparam int c_MSB = WIDTH - 1;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic               r_sign;     // sign to apply to the magnitude result
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    // mul: {partial product high, multiplier shifting out}
    // div: {partial remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_out;
    logic               r_done, r_busy, r_zero, r_neg, r_ovf, r_dbz;

    // ---------------- request decode ----------------
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic             w_multi, w_div_zero;

    // |MIN| = 2^(WIDTH-1) still fits in WIDTH unsigned bits
    assign w_mag_a    = a[c_MSB] ? -a : a;
    assign w_mag_b    = b[c_MSB] ? -b : b;
    assign w_multi    = (alu_op == c_OP_MUL) || (alu_op == c_OP_DIV) || (alu_op == c_OP_MOD);
    assign w_div_zero = ((alu_op == c_OP_DIV) || (alu_op == c_OP_MOD)) && (b == '0);

    // ---------------- single-cycle results ----------------
    logic [WIDTH-1:0] w_sum, w_diff, w_fast_res;
    logic             w_fast_ovf, w_fast_dbz;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        w_fast_res = '0;
        w_fast_ovf = 1'b0;
        w_fast_dbz = 1'b0;
        case (alu_op)
            c_OP_ADD: begin
                w_fast_res = w_sum;
                w_fast_ovf = (a[c_MSB] == b[c_MSB]) && (w_sum[c_MSB] != a[c_MSB]);
            end
            c_OP_SUB: begin
                w_fast_res = w_diff;
                w_fast_ovf = (a[c_MSB] != b[c_MSB]) && (w_diff[c_MSB] != a[c_MSB]);
            end
            c_OP_AND: w_fast_res = a & b;
            c_OP_OR:  w_fast_res = a | b;
            c_OP_XOR: w_fast_res = a ^ b;
            c_OP_DIV: begin
                w_fast_res = '1;
                w_fast_dbz = 1'b1;
            end
            c_OP_MOD: begin
                w_fast_res = a;
                w_fast_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- iteration step ----------------
    logic [WIDTH:0] w_mul_hi, w_div_shift, w_div_trial;
    logic           w_div_ok;

    assign w_mul_hi    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_mag_b};
    assign w_div_ok    = ~w_div_trial[WIDTH];   // no borrow: divisor fits

    // ---------------- final sign fix-up ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem, w_fin_res;
    logic               w_fin_ovf;

    assign w_prod = r_sign ? -r_acc : r_acc;
    assign w_quot = r_sign ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sign ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fin_res = w_rem;
        w_fin_ovf = 1'b0;
        case (r_op)
            c_OP_MUL: begin
                w_fin_res = w_prod[WIDTH-1:0];
                // fits iff the upper half plus the result MSB are a pure sign extension
                w_fin_ovf = !((&w_prod[2*WIDTH-1:c_MSB]) || !(|w_prod[2*WIDTH-1:c_MSB]));
            end
            c_OP_DIV: begin
                w_fin_res = w_quot;
                // a positive quotient of 2^(WIDTH-1) only arises from MIN / -1
                w_fin_ovf = !r_sign && r_acc[c_MSB];
            end
            default: ;
        endcase
    end

    // ---------------- control and state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_sign  <= 1'b0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (w_multi && !w_div_zero) begin
                            r_op    <= alu_op;
                            r_mag_a <= w_mag_a;
                            r_mag_b <= w_mag_b;
                            r_sign  <= (alu_op == c_OP_MOD) ? a[c_MSB] : (a[c_MSB] ^ b[c_MSB]);
                            r_acc   <= {{WIDTH{1'b0}}, (alu_op == c_OP_MUL) ? w_mag_b : w_mag_a};
                            r_cnt   <= c_CNT_LOAD;
                            r_busy  <= 1'b1;
                            r_state <= c_ST_RUN;
                        end else begin
                            r_out  <= w_fast_res;
                            r_zero <= (w_fast_res == '0);
                            r_neg  <= w_fast_res[c_MSB];
                            r_ovf  <= w_fast_ovf;
                            r_dbz  <= w_fast_dbz;
                            r_done <= 1'b1;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_op == c_OP_MUL) begin
                        r_acc <= {w_mul_hi, r_acc[WIDTH-1:1]};
                    end else begin
                        r_acc <= {(w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                                  r_acc[WIDTH-2:0], w_div_ok};
                    end
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_ST_FIN;
                    end
                end
                c_ST_FIN: begin
                    r_out   <= w_fin_res;
                    r_zero  <= (w_fin_res == '0);
                    r_neg   <= w_fin_res[c_MSB];
                    r_ovf   <= w_fin_ovf;
                    r_dbz   <= 1'b0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign alu_out = r_out;
    assign done    = r_done;
    assign busy    = r_busy;
    assign zero    = r_zero;
    assign neg     = r_neg;
    assign ovf     = r_ovf;
    assign dbz     = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Directed self-checking bench for seq_alu (WIDTH = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam logic [2:0] c_ADD = 3'b000, c_SUB = 3'b001, c_AND = 3'b010, c_OR = 3'b011;
    localparam logic [2:0] c_XOR = 3'b100, c_MUL = 3'b101, c_DIV = 3'b110, c_MOD = 3'b111;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  alu_op;
    logic [15:0] a, b;
    logic [15:0] alu_out;
    logic        done, busy, zero, neg, ovf, dbz;

    int total = 0;
    int bad   = 0;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
        .alu_out(alu_out), .done(done), .busy(busy),
        .zero(zero), .neg(neg), .ovf(ovf), .dbz(dbz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one op; lat = negedges after the start edge until done is seen,
    // bcnt = negedges with busy high. Operands are scrambled while waiting.
    task automatic do_op(input logic [2:0] op, input logic [15:0] xa, input logic [15:0] xb,
                         output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; alu_op = op; a = xa; b = xb;
        bcnt = 0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            a = 16'($urandom); b = 16'($urandom); alu_op = 3'($urandom);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++; if ({alu_out, done, busy, zero, neg, ovf, dbz} !== 22'd0) begin bad++; $display("FAIL reset outputs got=%h exp=0", {alu_out, done, busy, zero, neg, ovf, dbz}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addsub_logic();
        int lat, bc;
        do_op(c_ADD, 16'h7FFF, 16'h0001, lat, bc);
        total++; if (alu_out !== 16'h8000) begin bad++; $display("FAIL add_ovf out got=%h exp=8000", alu_out); end
        total++; if ({zero, neg, ovf, dbz} !== 4'b0110) begin bad++; $display("FAIL add_ovf flags got=%b exp=0110", {zero, neg, ovf, dbz}); end
        do_op(c_SUB, 16'd5, 16'd5, lat, bc);
        total++; if (alu_out !== 16'h0000) begin bad++; $display("FAIL sub_zero out got=%h exp=0000", alu_out); end
        total++; if ({zero, neg, ovf, dbz} !== 4'b1000) begin bad++; $display("FAIL sub_zero flags got=%b exp=1000", {zero, neg, ovf, dbz}); end
        total++; if (lat !== 1) begin bad++; $display("FAIL sub_latency got=%0d exp=1", lat); end
        do_op(c_SUB, 16'h8000, 16'h0001, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h7FFF, 4'b0010}) begin bad++; $display("FAIL sub_ovf got=%h/%b exp=7fff/0010", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_AND, 16'hF0F0, 16'h3C3C, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h3030, 4'b0000}) begin bad++; $display("FAIL and got=%h/%b exp=3030/0000", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_OR, 16'hF0F0, 16'h3C3C, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'hFCFC, 4'b0100}) begin bad++; $display("FAIL or got=%h/%b exp=fcfc/0100", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_XOR, 16'hF0F0, 16'h3C3C, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'hCCCC, 4'b0100}) begin bad++; $display("FAIL xor got=%h/%b exp=cccc/0100", alu_out, {zero, neg, ovf, dbz}); end
    endtask

    task automatic test_mul();
        int lat, bc;
        do_op(c_MUL, -16'sd123, 16'sd45, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'hEA61, 4'b0100}) begin bad++; $display("FAIL mul_neg got=%h/%b exp=ea61/0100", alu_out, {zero, neg, ovf, dbz}); end
        total++; if (lat !== 18) begin bad++; $display("FAIL mul_latency got=%0d exp=18", lat); end
        total++; if (bc !== 17) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=17", bc); end
        do_op(c_MUL, 16'd300, 16'd300, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h5F90, 4'b0010}) begin bad++; $display("FAIL mul_ovf got=%h/%b exp=5f90/0010", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_MUL, 16'sd256, -16'sd128, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h8000, 4'b0100}) begin bad++; $display("FAIL mul_min_fits got=%h/%b exp=8000/0100", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_MUL, 16'd256, 16'd128, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h8000, 4'b0110}) begin bad++; $display("FAIL mul_plus_min got=%h/%b exp=8000/0110", alu_out, {zero, neg, ovf, dbz}); end
    endtask

    task automatic test_divmod();
        int lat, bc;
        do_op(c_DIV, -16'sd7, 16'sd2, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'hFFFD, 4'b0100}) begin bad++; $display("FAIL div_m7_2 got=%h/%b exp=fffd/0100", alu_out, {zero, neg, ovf, dbz}); end
        total++; if (lat !== 18) begin bad++; $display("FAIL div_latency got=%0d exp=18", lat); end
        do_op(c_MOD, -16'sd7, 16'sd2, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'hFFFF, 4'b0100}) begin bad++; $display("FAIL mod_m7_2 got=%h/%b exp=ffff/0100", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_MOD, 16'sd7, -16'sd2, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h0001, 4'b0000}) begin bad++; $display("FAIL mod_7_m2 got=%h/%b exp=0001/0000", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_DIV, 16'sd7, -16'sd2, lat, bc);
        total++; if (alu_out !== 16'hFFFD) begin bad++; $display("FAIL div_7_m2 got=%h exp=fffd", alu_out); end
        do_op(c_DIV, 16'h8000, 16'hFFFF, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h8000, 4'b0110}) begin bad++; $display("FAIL div_min_m1 got=%h/%b exp=8000/0110", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_MOD, 16'h8000, 16'hFFFF, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h0000, 4'b1000}) begin bad++; $display("FAIL mod_min_m1 got=%h/%b exp=0000/1000", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_DIV, 16'd100, 16'd7, lat, bc);
        total++; if (alu_out !== 16'h000E) begin bad++; $display("FAIL div_100_7 got=%h exp=000e", alu_out); end
        do_op(c_MOD, -16'sd100, 16'sd7, lat, bc);
        total++; if (alu_out !== 16'hFFFE) begin bad++; $display("FAIL mod_m100_7 got=%h exp=fffe", alu_out); end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        do_op(c_DIV, 16'd9, 16'd0, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'hFFFF, 4'b0101}) begin bad++; $display("FAIL div0 got=%h/%b exp=ffff/0101", alu_out, {zero, neg, ovf, dbz}); end
        total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d exp=1", lat); end
        do_op(c_MOD, 16'd9, 16'd0, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h0009, 4'b0001}) begin bad++; $display("FAIL mod0 got=%h/%b exp=0009/0001", alu_out, {zero, neg, ovf, dbz}); end
        do_op(c_ADD, 16'd1, 16'd1, lat, bc);
        total++; if ({alu_out, zero, neg, ovf, dbz} !== {16'h0002, 4'b0000}) begin bad++; $display("FAIL dbz_clear got=%h/%b exp=0002/0000", alu_out, {zero, neg, ovf, dbz}); end
    endtask

    task automatic test_start_held();
        int lat, ndone;
        logic [15:0] res;
        lat = 0; ndone = 0; res = '0;
        @(negedge clk);
        start = 1'b1; alu_op = c_MUL; a = 16'd7; b = 16'd3;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin alu_op = c_ADD; a = 16'd1; b = 16'd1; end
            if (i == 12) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin lat = i; res = alu_out; end
            end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL held_start_dones got=%0d exp=1", ndone); end
        total++; if (lat !== 18) begin bad++; $display("FAIL held_start_latency got=%0d exp=18", lat); end
        total++; if (res !== 16'd21) begin bad++; $display("FAIL held_start_result got=%h exp=0015", res); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [15:0] r1, r2;
        first = 0; second = 0; r1 = '0; r2 = '0;
        @(negedge clk);
        start = 1'b1; alu_op = c_MUL; a = 16'd100; b = 16'd3;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                if (first == 0) begin
                    first = i; r1 = alu_out;
                    start = 1'b1; alu_op = c_MUL; a = -16'sd20; b = -16'sd20;
                end else if (second == 0) begin
                    second = i; r2 = alu_out;
                end
            end
        end
        total++; if (first !== 18) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=18", first); end
        total++; if (r1 !== 16'd300) begin bad++; $display("FAIL b2b_first_result got=%h exp=012c", r1); end
        total++; if (second !== 36) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=36", second); end
        total++; if (r2 !== 16'd400) begin bad++; $display("FAIL b2b_second_result got=%h exp=0190", r2); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, bc, ndone;
        do_op(c_ADD, 16'h1234, 16'h0001, lat, bc);
        @(negedge clk);
        start = 1'b1; alu_op = c_MUL; a = 16'd7; b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_mul_busy got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        total++; if ({alu_out, done, busy, zero, neg, ovf, dbz} !== 22'd0) begin bad++; $display("FAIL async_reset outputs got=%h exp=0", {alu_out, done, busy, zero, neg, ovf, dbz}); end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL aborted_done got=%0d exp=0", ndone); end
        do_op(c_ADD, 16'd2, 16'd2, lat, bc);
        total++; if (alu_out !== 16'd4) begin bad++; $display("FAIL post_reset_add got=%h exp=0004", alu_out); end
        total++; if (lat !== 1) begin bad++; $display("FAIL post_reset_latency got=%0d exp=1", lat); end
    endtask

    initial begin
        test_reset();
        test_addsub_logic();
        test_mul();
        test_divmod();
        test_div_by_zero();
        test_start_held();
        test_back_to_back();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
